// File: rtl/branch_predict_gshare.sv
// branch_predict_gshare: gshare direction predictor with speculative and retired global history.
// Optional BP_STATS_EN adds branch_cnt/mispred_cnt performance counters.
module branch_predict_gshare #(
  parameter int IDX_W = 10,
  parameter int GHR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic        flushE,
  input  logic [31:0] pcF,
  input  logic        branchD,
  input  logic        branchM,
  input  logic        actual_takeM,
  output logic        pred_takeD,
`ifdef BP_STATS_EN
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt,
`endif
  output logic        pred_resM
);
  logic [1:0]       pht [2**IDX_W];
  logic [GHR_W-1:0] ghrSpec, ghrRet, ghrRetNext;
  logic [IDX_W-1:0] idxF, idxD, idxE, idxM;
  logic [1:0]       cntF, cntD, cntM, cntNext;
  logic             predE, predM, validE, validM, updM, unusedPc;
  assign unusedPc   = ^{pcF[31:IDX_W+2], pcF[1:0]};
  assign idxF       = pcF[IDX_W+1:2] ^ IDX_W'(ghrSpec);
  assign updM       = branchM & validM;
  assign cntM       = pht[idxM];
  assign cntNext    = actual_takeM ? (cntM == 2'b11 ? cntM : cntM + 2'b01)
                                   : (cntM == 2'b00 ? cntM : cntM - 2'b01);
  // write-first: a same-cycle retire to the fetched entry is visible to fetch
  assign cntF       = (updM && idxM == idxF) ? cntNext : pht[idxF];
  assign pred_takeD = branchD & cntD[1];
  assign pred_resM  = updM & (predM ^ actual_takeM);
  assign ghrRetNext = {ghrRet[GHR_W-2:0], actual_takeM};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) pht[i] <= 2'b01;
      ghrSpec <= '0;
      ghrRet  <= '0;
      idxD    <= '0;
      cntD    <= '0;
      idxE    <= '0;
      predE   <= 1'b0;
      validE  <= 1'b0;
      idxM    <= '0;
      predM   <= 1'b0;
      validM  <= 1'b0;
    end else begin
      if (updM) begin
        pht[idxM] <= cntNext;
        ghrRet    <= ghrRetNext;
      end
      if (flushD) begin
        idxD <= '0;
        cntD <= '0;
      end else if (!stallD) begin
        idxD <= idxF;
        cntD <= cntF;
      end
      idxE   <= flushE ? '0 : idxD;
      predE  <= flushE ? 1'b0 : pred_takeD;
      validE <= flushE ? 1'b0 : branchD;
      idxM   <= idxE;
      predM  <= predE;
      validM <= validE;
      // recovery wins over the wrong-path D shift, which gets flushed anyway
      if (pred_resM) ghrSpec <= ghrRetNext;
      else if (branchD && !stallD && !flushD) ghrSpec <= {ghrSpec[GHR_W-2:0], pred_takeD};
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      branch_cnt  <= branch_cnt + 32'(updM);
      mispred_cnt <= mispred_cnt + 32'(pred_resM);
    end
  end
`endif
endmodule
